// File: rtl/draw_fb_writer.sv
// Drawing-engine pixel sink: clips to the framebuffer, converts to a linear address and
// buffers writes in a small FIFO in front of a ready-handshaked memory port. Optional: CLIP_COUNT_EN.
module draw_fb_writer #(
    parameter int CORDW     = 16,
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 180,
    parameter int ADDRW     = 16,
    parameter int COLRW     = 4,
    parameter int DEPTH     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [CORDW-1:0] x,
    input  logic signed [CORDW-1:0] y,
    input  logic                    drawing,
    input  logic        [COLRW-1:0] colr,
    input  logic                    src_done,
    output logic                    oe,
    output logic                    fb_we,
    output logic        [ADDRW-1:0] fb_addr,
    output logic        [COLRW-1:0] fb_colr,
    input  logic                    fb_ready,
    output logic                    busy,
    output logic                    done,
    output logic             [15:0] clipped
);

    localparam int PtrW = $clog2(DEPTH);
    localparam int CntW = PtrW + 1;
    localparam logic signed [CORDW-1:0] FbW = CORDW'(FB_WIDTH);
    localparam logic signed [CORDW-1:0] FbH = CORDW'(FB_HEIGHT);
    localparam logic [CntW-1:0] OeLimit = CntW'(DEPTH - 3);
    localparam logic [CntW-1:0] Full    = CntW'(DEPTH);

    typedef enum logic [1:0] {Idle, Active, Flush} state_t;

    state_t            state_q, state_d;
    logic              done_q, done_d;
    logic              s1Valid_q, s1InBounds_q;
    logic [ADDRW-1:0]  s1Addr_q;
    logic [COLRW-1:0]  s1Colr_q;
    logic [ADDRW-1:0]  memAddr_q [DEPTH];
    logic [COLRW-1:0]  memColr_q [DEPTH];
    logic [PtrW-1:0]   wrPtr_q, rdPtr_q;
    logic [CntW-1:0]   count_q, count_d;

    logic              inBounds, empty, push, pop;
    logic [ADDRW-1:0]  pixAddr;
    logic [CntW-1:0]   occupancy;

    assign inBounds = !x[CORDW-1] && (x < FbW) && !y[CORDW-1] && (y < FbH);
    assign pixAddr  = ADDRW'($unsigned(y)) * ADDRW'(FB_WIDTH) + ADDRW'($unsigned(x));

    assign empty = (count_q == '0);
    assign pop   = !empty && fb_ready;
    assign push  = s1Valid_q && s1InBounds_q && ((count_q != Full) || pop);

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid_q    <= 1'b0;
            s1InBounds_q <= 1'b0;
            s1Addr_q     <= '0;
            s1Colr_q     <= '0;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            count_q      <= '0;
        end else begin
            s1Valid_q <= drawing;
            if (drawing) begin
                s1InBounds_q <= inBounds;
                s1Addr_q     <= pixAddr;
                s1Colr_q     <= colr;
            end
            if (push) wrPtr_q <= wrPtr_q + PtrW'(1);
            if (pop)  rdPtr_q <= rdPtr_q + PtrW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            memAddr_q[wrPtr_q] <= s1Addr_q;
            memColr_q[wrPtr_q] <= s1Colr_q;
        end
    end

    // Flush completes on the edge that leaves both S1 and the FIFO empty, so done and the
    // fall of busy appear in the cycle right after the final accepted write.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            Idle:    if (start) state_d = Active;
            Active:  if (src_done) state_d = Flush;
            Flush: begin
                if ((count_d == '0) && !drawing) begin
                    state_d = Idle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= Idle;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign occupancy = count_q + CntW'(s1Valid_q);
    assign oe        = (occupancy <= OeLimit);
    assign fb_we     = !empty;
    assign fb_addr   = empty ? '0 : memAddr_q[rdPtr_q];
    assign fb_colr   = empty ? '0 : memColr_q[rdPtr_q];
    assign busy      = (state_q != Idle);
    assign done      = done_q;

`ifdef CLIP_COUNT_EN
    logic [15:0] clipped_q;

    // A new request clears the count, taking priority over a clip on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clipped_q <= '0;
        end else if ((state_q == Idle) && start) begin
            clipped_q <= '0;
        end else if (s1Valid_q && !s1InBounds_q && (clipped_q != 16'hFFFF)) begin
            clipped_q <= clipped_q + 16'd1;
        end
    end

    assign clipped = clipped_q;
`else
    assign clipped = '0;
`endif

endmodule
